// File: rtl/operand_fetch_buffer.sv
// operand_fetch_buffer
//   Muxes one of three operand sources (register, immediate, memory) using the
//   decoder's active-low one-hot select and queues the chosen operand in a
//   2-entry FIFO with valid/ready handshakes on both sides.
//   Illegal select codes still complete the input handshake, but they only
//   raise a sticky error flag and do not write an entry.
//   Optional build macro: OPSEL_ERR_COUNT_EN adds an 8-bit saturating
//   illegal-select counter (err_count). In that build sel_err is derived from
//   the counter.
//   The 14ns clock-to-Q figure used by the gate-delay models elsewhere is not
//   modelled here. This file is the synthesizable view only.
module operand_fetch_buffer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            opDataSelector_,
    input  logic [DATA_WIDTH-1:0] regData,
    input  logic [DATA_WIDTH-1:0] immData,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef OPSEL_ERR_COUNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  sel_err
);

    // FIFO occupancy is the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifoState_e;

    fifoState_e state, stateNext;

    logic                       selLegal;
    logic [DATA_WIDTH-1:0]      selData;
    logic                       push, pop, legalPush, illegalPush;
    logic [1:0][DATA_WIDTH-1:0] bufMem;
    logic                       wptr, rptr, rptrNext;
    logic [DATA_WIDTH-1:0]      headNext;

    // Select decode: a code is legal only when exactly one bit is low.
    always_comb begin
        selLegal = 1'b1;
        selData  = '0;
        case (opDataSelector_)
            3'b110:  selData = regData;
            3'b101:  selData = immData;
            3'b011:  selData = memData;
            default: selLegal = 1'b0;
        endcase
    end

    // Handshakes depend only on registered state, so no in_valid-to-out_valid path exists.
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign legalPush   = push & selLegal;
    assign illegalPush = push & ~selLegal;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= stateNext;
    end

    // Next-state logic: illegal pushes never change occupancy.
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: if (legalPush) stateNext = ONE;
            ONE: begin
                case ({legalPush, pop})
                    2'b10:   stateNext = FULL;
                    2'b01:   stateNext = EMPTY;
                    default: stateNext = ONE;
                endcase
            end
            FULL:    if (pop) stateNext = ONE;
            default: stateNext = EMPTY;
        endcase
    end

    // Output decode from state: ready while not full, valid while not empty.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    // Storage and pointers. Source data is sampled only on a legal push edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bufMem <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
        end else begin
            if (legalPush) begin
                bufMem[wptr] <= selData;
                wptr         <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
        end
    end

    // Head for the next cycle. Data written this edge into the slot that
    // becomes the head must bypass storage.
    always_comb begin
        rptrNext = rptr ^ pop;
        if (legalPush && (wptr == rptrNext)) headNext = selData;
        else                                 headNext = bufMem[rptrNext];
    end

    // Registered operand: it follows the head and holds its last value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset)                   operand <= '0;
        else if (stateNext != EMPTY) operand <= headNext;
    end

`ifdef OPSEL_ERR_COUNT_EN
    // Saturating illegal-select counter. The sticky flag is derived from it.
    always_ff @(posedge clk) begin
        if (reset)                              err_count <= 8'd0;
        else if (illegalPush && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end

    assign sel_err = (err_count != 8'd0);
`else
    // Sticky illegal-select flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)            sel_err <= 1'b0;
        else if (illegalPush) sel_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_operand_fetch_buffer.sv
// Scoreboard bench for operand_fetch_buffer. The stimulus process drives
// directed and random traffic. A reference model pushes expected operands into
// a queue, and a negedge monitor checks handshakes and flags and pops
// expectations on each output transfer.
module tb_operand_fetch_buffer;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    sel;
    logic [DW-1:0] regD, immD, memD;
    logic          inValid, outReady;
    logic          inReady, outValid, selErr;
    logic [DW-1:0] operand;
`ifdef OPSEL_ERR_COUNT_EN
    logic [7:0]    errCount;
`endif

    operand_fetch_buffer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .opDataSelector_(sel),
        .regData(regD), .immData(immD), .memData(memD),
        .in_valid(inValid), .in_ready(inReady),
        .operand(operand), .out_valid(outValid), .out_ready(outReady),
`ifdef OPSEL_ERR_COUNT_EN
        .err_count(errCount),
`endif
        .sel_err(selErr)
    );

    always #5 clk = ~clk;

    int            nVec = 0, nErr = 0;
    logic [DW-1:0] expQ[$];
    int            level = 0;
    bit            expErr = 1'b0;
    int            expCnt = 0;
    bit            checkOn = 1'b0;
    bit            justReset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two operands, where an illegal select
    // produces only an error event.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            level = 0; expQ.delete(); expErr = 1'b0; expCnt = 0; justReset = 1'b1;
        end else begin
            bit doPush, doPop;
            justReset = 1'b0;
            doPush = inValid && (level != 2);
            doPop  = (level != 0) && outReady;
            if (doPop) level--;
            if (doPush) begin
                if ($countones(~sel) == 1) begin
                    logic [DW-1:0] d;
                    if (!sel[0])      d = regD;
                    else if (!sel[1]) d = immD;
                    else              d = memD;
                    level++;
                    expQ.push_back(d);
                end else begin
                    expErr = 1'b1;
                    if (expCnt < 255) expCnt++;
                end
            end
        end
    end

    // Monitor: checks the handshake and flag outputs every cycle, and the operand against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (checkOn) begin
            chk("in_ready", 32'(inReady), 32'(level != 2));
            chk("out_valid", 32'(outValid), 32'(level != 0));
            chk("sel_err", 32'(selErr), 32'(expErr));
`ifdef OPSEL_ERR_COUNT_EN
            chk("err_count", 32'(errCount), 32'(expCnt));
`endif
            if (justReset) chk("operand_after_reset", 32'(operand), 32'd0);
            if (outValid) begin
                if (expQ.size() == 0) begin
                    chk("scoreboard_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("operand", 32'(operand), 32'(expQ[0]));
                    if (outReady) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] s, input logic [DW-1:0] d, input logic r);
        inValid = v; sel = s; regD = d; immD = d; memD = d; outReady = r;
    endtask

    logic [2:0] legalCodes [3] = '{3'b110, 3'b101, 3'b011};

    initial begin
        reset = 1'b1; drv(1'b0, 3'b111, '0, 1'b0);
        cyc(); checkOn = 1'b1; cyc();
        reset = 1'b0;
        // Reset to push to pop.
        drv(1'b1, 3'b110, 16'h1234, 1'b0); cyc();
        drv(1'b0, 3'b111, 16'h0, 1'b0);    cyc();
        outReady = 1'b1;                    cyc();
        // Fill and backpressure.
        drv(1'b1, 3'b101, 16'hAAAA, 1'b0); cyc();
        drv(1'b1, 3'b011, 16'h5555, 1'b0); cyc();
        drv(1'b1, 3'b110, 16'hDEAD, 1'b0); cyc(); cyc();
        drv(1'b0, 3'b111, 16'h0, 1'b1);    cyc(); cyc(); cyc();
        // Simultaneous push and pop at a count of one.
        drv(1'b1, 3'b110, 16'h0001, 1'b0); cyc();
        drv(1'b1, 3'b110, 16'h0002, 1'b1); cyc();
        drv(1'b0, 3'b111, 16'h0, 1'b1);    cyc(); cyc();
        // Illegal selects.
        drv(1'b1, 3'b111, 16'h7777, 1'b0); cyc();
        drv(1'b1, 3'b100, 16'h8888, 1'b0); cyc();
        drv(1'b0, 3'b111, 16'h0, 1'b0);    cyc();
        // Reset while the FIFO is full.
        drv(1'b1, 3'b110, 16'h0A0A, 1'b0); cyc();
        drv(1'b1, 3'b011, 16'h0B0B, 1'b0); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        drv(1'b0, 3'b111, 16'h0, 1'b0);    cyc();
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sel = 3'($urandom);
            else                           sel = legalCodes[$urandom_range(0, 2)];
            regD = 16'($urandom); immD = 16'($urandom); memD = 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
`ifdef OPSEL_ERR_COUNT_EN
        // Counter saturation.
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 260; i++) begin
            drv(1'b1, 3'b000, 16'($urandom), 1'b1);
            cyc();
        end
        drv(1'b0, 3'b111, 16'h0, 1'b1); cyc();
        chk("err_count_saturated", 32'(errCount), 32'd255);
`endif
        drv(1'b0, 3'b111, 16'h0, 1'b0); cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
